fifo_rd_stream_stage: RTL

//  Read-side output stage of the async FIFO, in the read clock domain, directly downstream of the read controller.

---
 rtl/fifo_rd_stream_stage.sv | 92 +++++++++
 1 files changed

// File: rtl/fifo_rd_stream_stage.sv
// Read-side output stage of the async FIFO: turns the rinc/rempty pop interface into a
// registered first-word-fall-through valid/ready stream through a 2-entry head/skid buffer.
module fifo_rd_stream_stage #(
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic                  r_clk,
   input  logic                  r_rst,
   input  logic                  rempty,
   input  logic [DATA_WIDTH-1:0] rdata,
   output logic                  rinc,
   input  logic                  flush,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic [1:0]            level
);

   typedef enum logic [1:0] {
      L0 = 2'd0,
      L1 = 2'd1,
      L2 = 2'd2
   } lvl_e;

   lvl_e                  state;
   lvl_e                  state_nxt;
   logic                  run;
   logic [DATA_WIDTH-1:0] head;
   logic [DATA_WIDTH-1:0] skid;
   logic [DATA_WIDTH-1:0] head_nxt;
   logic [DATA_WIDTH-1:0] skid_nxt;
   logic                  push;
   logic                  pop;

   // Pop decision looks only at local state, so m_ready never reaches rinc.
   assign rinc    = run & ~rempty & ~flush & (state != L2);
   assign push    = rinc;
   assign m_valid = (state != L0);
   assign pop     = m_valid & m_ready;
   assign m_data  = head;
   assign level   = state;

   always_ff @(posedge r_clk or negedge r_rst) begin
      if (!r_rst) begin
         state <= L0;
         run   <= 1'b0;
         head  <= '0;
         skid  <= '0;
      end else begin
         state <= state_nxt;
         run   <= 1'b1;
         head  <= head_nxt;
         skid  <= skid_nxt;
      end
   end

   // Flush only clears the level; head is left alone so m_data keeps its last value.
   always_comb begin
      state_nxt = state;
      head_nxt  = head;
      skid_nxt  = skid;
      if (flush) begin
         state_nxt = L0;
      end else begin
         case (state)
            L0: begin
               if (push) begin
                  head_nxt  = rdata;
                  state_nxt = L1;
               end
            end
            L1: begin
               if (push && !pop) begin
                  skid_nxt  = rdata;
                  state_nxt = L2;
               end else if (push && pop) begin
                  head_nxt  = rdata;
               end else if (pop) begin
                  state_nxt = L0;
               end
            end
            L2: begin
               if (pop) begin
                  head_nxt  = skid;
                  state_nxt = L1;
               end
            end
            default: state_nxt = L0;
         endcase
      end
   end

endmodule
